// File: rtl/block_data_memory_if.sv
// Cache<->memory block interface.
// The data cache (master) raises read or write with an address and, for writes,
// the block to store; the memory (slave) answers with busywait and readdata.
interface block_data_memory_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              busywait;

    modport master (
        output read, write, address, writedata,
        input  readdata, busywait
    );

    modport slave (
        input  read, write, address, writedata,
        output readdata, busywait
    );
endinterface

// File: rtl/block_data_memory.sv
// block_data_memory: main-memory responder below the data cache.
// 2**ADDR_W blocks of DATA_W bits, whole-block read/write, LATENCY access cycles
// per request, busywait handshake.
// Optional macro DMEM_PATTERN_INIT_EN: when defined, block i powers up holding
// the byte ramp {4i+3, 4i+2, 4i+1, 4i} (byte 0 in the low lane); otherwise every
// block powers up as zero. Reset never touches the array contents.
module block_data_memory #(
    parameter int LATENCY = 5,
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    block_data_memory_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef logic [DEPTH-1:0][DATA_W-1:0] mem_image_t;

    // Power-up image of the array.
    function automatic mem_image_t mem_init();
        mem_image_t img;
        img = '0;
`ifdef DMEM_PATTERN_INIT_EN
        for (int i = 0; i < DEPTH; i++) begin
            for (int b = 0; b < BYTES; b++) begin
                img[i][8*b +: 8] = 8'(BYTES * i + b);
            end
        end
`endif
        return img;
    endfunction

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              op_write_q;
    logic [DATA_W-1:0] readdata_q;
    logic              busy;
    logic              start;
    logic              commit;

    // The array holds its power-up image from time zero; only committed writes change it.
    mem_image_t mem = mem_init();

    // A request is legal only when exactly one of read/write is raised.
    logic req_valid;
    assign req_valid = bus.read ^ bus.write;

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus handshake and datapath strobes.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        busy       = 1'b0;
        start      = 1'b0;
        commit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    busy       = 1'b1;
                    start      = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    commit     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the request in IDLE and count down the access latency.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt        <= CNT_W'(LATENCY - 1);
            addr_q     <= bus.address;
            wdata_q    <= bus.writedata;
            op_write_q <= bus.write;
        end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Read data register: loaded only when a read completes, cleared by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            readdata_q <= '0;
        end else if (commit && !op_write_q) begin
            readdata_q <= mem[addr_q];
        end
    end

    // Array write port: a write lands only on the final access cycle.
    always_ff @(posedge clock) begin
        // NOTE: the array is deliberately not reset; reset only blocks an in-flight write from landing.
        if (!reset && commit && op_write_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

    assign bus.busywait = busy;
    assign bus.readdata = readdata_q;

endmodule
